// File: rtl/mult_batch_pkg.sv
// Shared definitions for the multiplier batch controller.
// Contents:
//   S_IDLE/S_INPUT/S_EXEC/S_OUTPUT   two-bit state encodings (also driven on STATE)
//   DEPTH_DEFAULT                    default batch size in operand pairs
//   CW_DEFAULT                       default counter width, wide enough to hold DEPTH_DEFAULT
//   cnt_width()                      counter width needed to represent the value depth
package mult_batch_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INPUT  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    // Counters must hold the value depth itself, not just depth-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEPTH_DEFAULT = 16;
    localparam int CW_DEFAULT    = cnt_width(DEPTH_DEFAULT);

endpackage

// File: rtl/mult_batch_ctrl_counter.sv
// batch_counter: CW-bit up-counter used for the per-phase transfer counts.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear (wins over en)
//   en     in   count enable
//   count  out  current count
//   tc     out  terminal flag: count == DEPTH-1 while en is high
module batch_counter
    import mult_batch_pkg::*;
#(
    parameter int CW    = CW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = en && (count == LAST);

endmodule

// File: rtl/mult_batch_ctrl.sv
// mult_batch_ctrl: sequences one batch of DEPTH operand pairs through
// operand FIFO -> combinational multiplier -> result FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START; final X_VALID/DONE land here
// S_INPUT  | requesting pairs from the source, writing operand FIFO
// S_EXEC   | reading operand FIFO, result FIFO written one cycle later
// S_OUTPUT | reading result FIFO, X_VALID one cycle later
//
// Ports:
//   CLK, RST                      clock, async active-low reset
//   START, HALT, ACK              batch start, abort (level), source valid
//   REQ_AB                        request operand pairs from the source
//   FIFO0_WR/RD, FIFO0_EMPTY      operand FIFO strobes and status
//   FIFO1_WR/RD, FIFO1_AFULL/EMPTY result FIFO strobes and status
//   X_VALID                       result FIFO DOUT holds a valid product
//   BUSY, DONE, ABORT, STATE      status and debug
module mult_batch_ctrl
    import mult_batch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       HALT,
    input  logic       ACK,
    output logic       REQ_AB,
    output logic       FIFO0_WR,
    input  logic       FIFO0_EMPTY,
    output logic       FIFO0_RD,
    output logic       FIFO1_WR,
    input  logic       FIFO1_AFULL,
    input  logic       FIFO1_EMPTY,
    output logic       FIFO1_RD,
    output logic       X_VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       ABORT,
    output logic [1:0] STATE
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] ex_cnt;
    logic [CW-1:0] out_cnt;
    logic          in_tc;
    logic          ex_tc;
    logic          out_tc;
    logic          start_go;
    logic          halt_take;
    logic          fifo1_wr_q;
    logic          x_valid_q;
    logic          done_q;
    logic          abort_q;
    logic [CW:0]   rd_issued;

    assign start_go  = (state_q == S_IDLE) && START && !HALT;
    assign halt_take = (state_q != S_IDLE) && HALT;

    // Reads issued so far = completed result writes plus the one in flight.
    assign rd_issued = {1'b0, ex_cnt} + {{CW{1'b0}}, fifo1_wr_q};

    assign REQ_AB   = (state_q == S_INPUT) && (in_cnt < DEPTH_C) && !HALT;
    assign FIFO0_WR = REQ_AB && ACK;
    assign FIFO0_RD = (state_q == S_EXEC) && !FIFO0_EMPTY && !FIFO1_AFULL && !HALT
                      && (rd_issued < {1'b0, DEPTH_C});
    assign FIFO1_RD = (state_q == S_OUTPUT) && !FIFO1_EMPTY && !HALT
                      && (out_cnt < DEPTH_C);

    batch_counter #(.CW(CW), .DEPTH(DEPTH)) u_in_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (start_go),
        .en    (FIFO0_WR),
        .count (in_cnt),
        .tc    (in_tc)
    );

    batch_counter #(.CW(CW), .DEPTH(DEPTH)) u_ex_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (start_go),
        .en    (fifo1_wr_q),
        .count (ex_cnt),
        .tc    (ex_tc)
    );

    batch_counter #(.CW(CW), .DEPTH(DEPTH)) u_out_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (start_go),
        .en    (FIFO1_RD),
        .count (out_cnt),
        .tc    (out_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_go) state_d = S_INPUT;
            end
            S_INPUT: begin
                if (HALT)       state_d = S_IDLE;
                else if (in_tc) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (HALT)       state_d = S_IDLE;
                else if (ex_tc) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (HALT || out_tc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            fifo1_wr_q <= 1'b0;
            x_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo1_wr_q <= FIFO0_RD;
            x_valid_q  <= FIFO1_RD;
            // out_tc only fires on the last non-halted read, so an aborted
            // batch can never produce DONE.
            done_q     <= out_tc;
            abort_q    <= halt_take;
        end
    end

    assign FIFO1_WR = fifo1_wr_q;
    assign X_VALID  = x_valid_q;
    assign DONE     = done_q;
    assign ABORT    = abort_q;
    assign BUSY     = (state_q != S_IDLE);
    assign STATE    = state_q;

endmodule

// File: tb/tb_mult_batch_ctrl.sv
module tb_mult_batch_ctrl;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       HALT;
    logic       ACK;
    logic       REQ_AB;
    logic       FIFO0_WR;
    logic       FIFO0_EMPTY;
    logic       FIFO0_RD;
    logic       FIFO1_WR;
    logic       FIFO1_AFULL;
    logic       FIFO1_EMPTY;
    logic       FIFO1_RD;
    logic       X_VALID;
    logic       BUSY;
    logic       DONE;
    logic       ABORT;
    logic [1:0] STATE;

    int n_chk;
    int n_err;
    int n_wr0, n_rd0, n_wr1, n_rd1, n_xv, n_done, n_abort;
    int n_wr1_bad;
    int xv_at_done;
    int done_xv;
    logic prev_rd0;

    mult_batch_ctrl #(.DEPTH(4), .CW(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .HALT        (HALT),
        .ACK         (ACK),
        .REQ_AB      (REQ_AB),
        .FIFO0_WR    (FIFO0_WR),
        .FIFO0_EMPTY (FIFO0_EMPTY),
        .FIFO0_RD    (FIFO0_RD),
        .FIFO1_WR    (FIFO1_WR),
        .FIFO1_AFULL (FIFO1_AFULL),
        .FIFO1_EMPTY (FIFO1_EMPTY),
        .FIFO1_RD    (FIFO1_RD),
        .X_VALID     (X_VALID),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ABORT       (ABORT),
        .STATE       (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_cnt();
        n_wr0 = 0; n_rd0 = 0; n_wr1 = 0; n_rd1 = 0; n_xv = 0;
        n_done = 0; n_abort = 0; n_wr1_bad = 0; xv_at_done = 0; done_xv = 0;
        prev_rd0 = 1'b0;
    endtask

    // One clock cycle: sample mid-cycle, return just after the next rising edge.
    task automatic cyc();
        @(negedge CLK);
        if (FIFO0_WR) n_wr0++;
        if (FIFO0_RD) n_rd0++;
        if (FIFO1_WR) n_wr1++;
        if (FIFO1_RD) n_rd1++;
        if (X_VALID)  n_xv++;
        if (ABORT)    n_abort++;
        if (FIFO1_WR && !prev_rd0) n_wr1_bad++;
        prev_rd0 = FIFO0_RD;
        if (DONE) begin
            n_done++;
            xv_at_done = n_xv;
            done_xv    = int'(X_VALID);
        end
        @(posedge CLK);
        #1;
    endtask

    // START pulse then four ACK cycles.
    task automatic run_input();
        START = 1'b1;
        cyc();
        START = 1'b0;
        ACK = 1'b1;
        repeat (4) cyc();
        ACK = 1'b0;
    endtask

    task automatic run_to_idle();
        int k;
        k = 0;
        while (BUSY && k < 40) begin
            cyc();
            k++;
        end
        check_eq("idle_timeout", 32'(BUSY), 0);
        cyc();
    endtask

    task automatic run_to_output();
        int k;
        k = 0;
        while (STATE != 2'd3 && k < 10) begin
            cyc();
            k++;
        end
        check_eq("reach_output", 32'(STATE), 3);
    endtask

    initial begin
        int a, b;
        n_chk = 0;
        n_err = 0;
        clr_cnt();
        RST = 1'b0; START = 1'b0; HALT = 1'b0; ACK = 1'b0;
        FIFO0_EMPTY = 1'b0; FIFO1_AFULL = 1'b0; FIFO1_EMPTY = 1'b0;
        #3;
        check_eq("reset_outs", 32'({REQ_AB, FIFO0_WR, FIFO0_RD, FIFO1_WR, FIFO1_RD,
                                    X_VALID, BUSY, DONE, ABORT, STATE}), 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b1;
        cyc();

        // Nominal batch, ACK held high throughout
        clr_cnt();
        START = 1'b1;
        cyc();
        START = 1'b0;
        check_eq("nom_state_input", 32'(STATE), 1);
        ACK = 1'b1;
        repeat (4) cyc();
        check_eq("nom_state_exec", 32'(STATE), 2);
        check_eq("nom_wr0_4", n_wr0, 4);
        run_to_idle();
        ACK = 1'b0;
        check_eq("nom_wr0_total", n_wr0, 4);
        check_eq("nom_rd0", n_rd0, 4);
        check_eq("nom_wr1", n_wr1, 4);
        check_eq("nom_wr1_align", n_wr1_bad, 0);
        check_eq("nom_rd1", n_rd1, 4);
        check_eq("nom_xv", n_xv, 4);
        check_eq("nom_done", n_done, 1);
        check_eq("nom_done_4th_xv", xv_at_done, 4);
        check_eq("nom_done_with_xv", done_xv, 1);
        check_eq("nom_busy_low", 32'(BUSY), 0);
        check_eq("nom_no_abort", n_abort, 0);

        // Sparse ACK on cycles 1,4,5,9 (and a stray one on 10)
        clr_cnt();
        START = 1'b1;
        cyc();
        START = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 9)  check_eq("sparse_still_input", 32'(STATE), 1);
            if (k == 10) check_eq("sparse_exec", 32'(STATE), 2);
            ACK = (k == 1 || k == 4 || k == 5 || k == 9 || k == 10);
            cyc();
        end
        ACK = 1'b0;
        check_eq("sparse_wr0", n_wr0, 4);
        run_to_idle();
        check_eq("sparse_done", n_done, 1);
        check_eq("sparse_xv", n_xv, 4);

        // Backpressure after the 2nd operand read
        clr_cnt();
        run_input();
        check_eq("bp_state_exec", 32'(STATE), 2);
        cyc();
        cyc();
        check_eq("bp_rd0_2", n_rd0, 2);
        FIFO1_AFULL = 1'b1;
        a = n_rd0;
        b = n_wr1;
        repeat (3) cyc();
        FIFO1_AFULL = 1'b0;
        check_eq("bp_no_rd0", n_rd0 - a, 0);
        check_eq("bp_trailing_wr1", n_wr1 - b, 1);
        run_to_idle();
        check_eq("bp_rd0_total", n_rd0, 4);
        check_eq("bp_wr1_total", n_wr1, 4);
        check_eq("bp_wr1_align", n_wr1_bad, 0);
        check_eq("bp_done", n_done, 1);

        // HALT in EXEC after two reads
        clr_cnt();
        run_input();
        cyc();
        cyc();
        HALT = 1'b1;
        a = n_rd0;
        b = n_wr1;
        cyc();
        HALT = 1'b0;
        check_eq("halt_no_rd0", n_rd0 - a, 0);
        check_eq("halt_state_idle", 32'(STATE), 0);
        check_eq("halt_abort_now", 32'(ABORT), 1);
        cyc();
        cyc();
        cyc();
        check_eq("halt_abort_once", n_abort, 1);
        check_eq("halt_trailing_wr1", n_wr1 - b, 1);
        check_eq("halt_wr1_total", n_wr1, 2);
        check_eq("halt_no_done", n_done, 0);

        // START with HALT in IDLE stays idle
        START = 1'b1;
        HALT = 1'b1;
        cyc();
        START = 1'b0;
        HALT = 1'b0;
        check_eq("prio_halt_start", 32'(STATE), 0);
        cyc();
        check_eq("prio_still_idle", 32'(STATE), 0);

        // START during OUTPUT is ignored
        clr_cnt();
        FIFO1_EMPTY = 1'b1;
        run_input();
        run_to_output();
        START = 1'b1;
        cyc();
        START = 1'b0;
        check_eq("prio_start_in_output", 32'(STATE), 3);
        check_eq("prio_empty_no_rd1", n_rd1, 0);
        FIFO1_EMPTY = 1'b0;
        run_to_idle();
        check_eq("prio_xv", n_xv, 4);
        check_eq("prio_done", n_done, 1);

        // Async reset mid-OUTPUT
        clr_cnt();
        run_input();
        run_to_output();
        cyc();
        check_eq("rst_pre_xv", 32'(X_VALID), 1);
        #2;
        RST = 1'b0;
        #1;
        check_eq("rst_mid_outs", 32'({REQ_AB, FIFO0_WR, FIFO0_RD, FIFO1_WR, FIFO1_RD,
                                      X_VALID, BUSY, DONE, ABORT, STATE}), 0);
        RST = 1'b1;
        clr_cnt();
        cyc();
        cyc();
        check_eq("rst_no_abort", n_abort, 0);
        check_eq("rst_idle", 32'(STATE), 0);
        run_input();
        run_to_idle();
        check_eq("rst_clean_wr0", n_wr0, 4);
        check_eq("rst_clean_wr1", n_wr1, 4);
        check_eq("rst_clean_xv", n_xv, 4);
        check_eq("rst_clean_done", n_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_batch_ctrl.md
Name: mult_batch_ctrl

Overview:
Sequencing controller for the operand FIFO -> combinational multiplier -> result FIFO pipeline. It runs one batch of DEPTH operand pairs through four phases: collect, multiply, drain, idle. In each phase it drives the source handshake (REQ_AB/ACK), both FIFOs' read/write strobes and the X_VALID output qualifier. It sits at the top level beside the two FIFO instances and the multiplier, and replaces ad-hoc glue logic there.

Parameters:
DEPTH, 16, batch size in operand pairs; must not exceed FIFO capacity.
CW, 5, counter width; must hold the value DEPTH (clog2(DEPTH)+1).

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
START  in  1  begin a batch; sampled only in IDLE
HALT  in  1  abort the current batch; level-sensitive
ACK  in  1  source presents a valid {A,B} pair this cycle
REQ_AB  out  1  controller requests operand pairs
FIFO0_WR  out  1  write strobe to the operand FIFO
FIFO0_EMPTY  in  1  operand FIFO is empty
FIFO0_RD  out  1  read strobe to the operand FIFO
FIFO1_WR  out  1  write strobe to the result FIFO (multiplier output is valid)
FIFO1_AFULL  in  1  result FIFO is almost full
FIFO1_EMPTY  in  1  result FIFO is empty
FIFO1_RD  out  1  read strobe to the result FIFO
X_VALID  out  1  result FIFO DOUT is a valid product this cycle
BUSY  out  1  state is not IDLE
DONE  out  1  one-cycle pulse on the final X_VALID of a batch
ABORT  out  1  one-cycle pulse after a HALT is taken; top level uses it to flush the FIFOs
STATE  out  2  current state encoding, for debug

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; all counters 0; every output 0.
- States: IDLE=0, INPUT=1, EXEC=2, OUTPUT=3. Registered state, combinational next-state.
- Counters (each CW bits, cleared on IDLE->INPUT):
  - in_cnt: increments on FIFO0_WR.
  - ex_cnt: increments on FIFO1_WR.
  - out_cnt: increments on FIFO1_RD.
- IDLE:
  - START=1 and HALT=0 -> INPUT.
  - HALT has priority over START.
  - START outside IDLE is ignored.
- INPUT:
  - REQ_AB = (in_cnt < DEPTH) and not HALT; combinational.
  - FIFO0_WR = ACK and REQ_AB.
  - ACK while REQ_AB=0 is ignored.
  - Exit to EXEC in the cycle of the DEPTH-th write (in_cnt = DEPTH-1 and FIFO0_WR=1).
- EXEC:
  - FIFO0_RD = not FIFO0_EMPTY and not FIFO1_AFULL and not HALT, and is issued only while (issued reads) < DEPTH.
  - FIFO1_WR = FIFO0_RD registered (1-cycle latency matches FIFO read latency; the multiplier is combinational).
  - Exit to OUTPUT in the cycle of the DEPTH-th FIFO1_WR.
- OUTPUT:
  - FIFO1_RD = not FIFO1_EMPTY and not HALT and out_cnt < DEPTH.
  - X_VALID = FIFO1_RD registered (1 cycle).
  - Exit to IDLE in the cycle of the DEPTH-th FIFO1_RD. The final X_VALID and DONE therefore appear in the first IDLE cycle.
- Backpressure:
  - FIFO1_AFULL=1 stalls reads with zero slip; already-registered FIFO1_WR still completes.
  - FIFO0_EMPTY or FIFO1_EMPTY simply suppresses the corresponding read. There is no timeout.
- HALT in INPUT, EXEC or OUTPUT:
  - All combinational strobes (REQ_AB, FIFO0_WR, FIFO0_RD, FIFO1_RD) are 0 in the HALT cycle.
  - Next state is IDLE. ABORT=1 for exactly the following cycle.
  - An in-flight registered FIFO1_WR or X_VALID still asserts once.
  - DONE is not asserted for an aborted batch.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No ABORT pulse.

Decomposition:
- Package mult_batch_pkg holds:
  - state encodings S_IDLE, S_INPUT, S_EXEC, S_OUTPUT;
  - default DEPTH and CW constants;
  - a helper function for the counter-width calculation.
- One natural sub-module, batch_counter: CW-bit up-counter with synchronous clear, enable, and terminal flag (count = DEPTH-1 and enable). It is instantiated three times, for in_cnt, ex_cnt and out_cnt.

Test Plan:
All scenarios use DEPTH=4.
- Nominal batch: START pulse, ACK held high. Expect:
  - FIFO0_WR on 4 consecutive cycles, then EXEC.
  - 4 FIFO0_RD, each followed 1 cycle later by FIFO1_WR.
  - OUTPUT with 4 FIFO1_RD and 4 X_VALID.
  - DONE coincident with the 4th X_VALID; BUSY low afterwards.
- Sparse ACK: ACK on cycles 1, 4, 5 and 9 after START. Expect state INPUT until cycle 9 and exactly 4 FIFO0_WR. An extra ACK after the 4th is ignored (no 5th write).
- Backpressure: FIFO1_AFULL held for 3 cycles after the 2nd FIFO0_RD. Expect no FIFO0_RD for those 3 cycles and one trailing FIFO1_WR. The batch then completes with exactly 4 FIFO1_WR.
- HALT in EXEC after 2 reads. Expect:
  - no FIFO0_RD in the HALT cycle;
  - state IDLE next cycle, with ABORT=1 for 1 cycle;
  - exactly one trailing FIFO1_WR;
  - no DONE.
- Priorities: START and HALT together in IDLE leaves state IDLE. START pulsed during OUTPUT has no effect.
- Async reset asserted mid-OUTPUT between clock edges. Expect all outputs 0 and STATE=0 before the next edge. After release, a new START runs a clean batch.
